// File: rtl/tx_msg_prio_arbiter.sv
// tx_msg_prio_arbiter: priority table shared by a strict-priority egress port and a ready/valid control port
module tx_msg_prio_arbiter #(
    parameter int         NUM_MSGS     = 128,
    parameter logic [7:0] DEFAULT_PRIO = 8'hFF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        eg_req_valid,
    input  logic [15:0] eg_req_index,
    input  logic        eg_req_update,
    input  logic [7:0]  eg_req_prio,
    output logic        eg_resp_valid,
    output logic [7:0]  eg_resp_prio,
    input  logic        ctl_req_valid,
    output logic        ctl_req_ready,
    input  logic [15:0] ctl_req_index,
    input  logic        ctl_req_update,
    input  logic [7:0]  ctl_req_prio,
    output logic        ctl_resp_valid,
    input  logic        ctl_resp_ready,
    output logic [7:0]  ctl_resp_prio,
    output logic        index_err,
    output logic [15:0] ctl_starve_cnt
);
    localparam int LW = $clog2(NUM_MSGS);

    logic [7:0]  entries_q [NUM_MSGS];
    logic        started_q;
    logic        eg_resp_valid_q, eg_resp_valid_d;
    logic [7:0]  eg_resp_prio_q, eg_resp_prio_d;
    logic        ctl_resp_valid_q, ctl_resp_valid_d;
    logic [7:0]  ctl_resp_prio_q, ctl_resp_prio_d;
    logic        index_err_q, index_err_d;
    logic [15:0] starve_q, starve_d;
    logic        eg_acc, ctl_acc, acc, in_range, wr_en;
    logic [15:0] idx;
    logic [7:0]  wdata, rdata;

    // started_q keeps both ports closed during the first cycle after reset release
    assign ctl_req_ready  = started_q && !eg_req_valid && (!ctl_resp_valid_q || ctl_resp_ready);
    assign eg_resp_valid  = eg_resp_valid_q;
    assign eg_resp_prio   = eg_resp_prio_q;
    assign ctl_resp_valid = ctl_resp_valid_q;
    assign ctl_resp_prio  = ctl_resp_prio_q;
    assign index_err      = index_err_q;
    assign ctl_starve_cnt = starve_q;

    // Select the single accepted request, read its entry and form next response state
    always_comb begin
        eg_acc           = started_q && eg_req_valid;
        ctl_acc          = ctl_req_valid && ctl_req_ready;
        acc              = eg_acc || ctl_acc;
        idx              = eg_acc ? eg_req_index : ctl_req_index;
        wdata            = eg_acc ? eg_req_prio : ctl_req_prio;
        in_range         = idx[15:LW] == '0;
        rdata            = in_range ? entries_q[idx[LW-1:0]] : 8'h00;
        wr_en            = acc && in_range && (eg_acc ? eg_req_update : ctl_req_update);
        eg_resp_valid_d  = eg_acc;
        eg_resp_prio_d   = eg_acc ? rdata : 8'h00;
        ctl_resp_valid_d = ctl_acc || (ctl_resp_valid_q && !ctl_resp_ready);
        ctl_resp_prio_d  = ctl_acc ? rdata : (ctl_resp_valid_d ? ctl_resp_prio_q : 8'h00);
        index_err_d      = acc && !in_range;
        starve_d         = (ctl_req_valid && eg_req_valid && starve_q != 16'hFFFF) ? starve_q + 16'd1 : starve_q;
    end

    // Priority table: write commits at the end of the acceptance cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_MSGS; i++) entries_q[i] <= DEFAULT_PRIO;
        end else if (wr_en) begin
            entries_q[idx[LW-1:0]] <= wdata;
        end
    end

    // Response, error and starvation registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            started_q        <= 1'b0;
            eg_resp_valid_q  <= 1'b0;
            eg_resp_prio_q   <= 8'h00;
            ctl_resp_valid_q <= 1'b0;
            ctl_resp_prio_q  <= 8'h00;
            index_err_q      <= 1'b0;
            starve_q         <= 16'h0000;
        end else begin
            started_q        <= 1'b1;
            eg_resp_valid_q  <= eg_resp_valid_d;
            eg_resp_prio_q   <= eg_resp_prio_d;
            ctl_resp_valid_q <= ctl_resp_valid_d;
            ctl_resp_prio_q  <= ctl_resp_prio_d;
            index_err_q      <= index_err_d;
            starve_q         <= starve_d;
        end
    end
endmodule

// File: tb/tb_tx_msg_prio_arbiter.sv
// tb_tx_msg_prio_arbiter: directed scenarios plus randomized traffic against a table model
module tb_tx_msg_prio_arbiter;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        eg_req_valid = 1'b0;
    logic [15:0] eg_req_index = '0;
    logic        eg_req_update = 1'b0;
    logic [7:0]  eg_req_prio = '0;
    logic        eg_resp_valid;
    logic [7:0]  eg_resp_prio;
    logic        ctl_req_valid = 1'b0;
    logic        ctl_req_ready;
    logic [15:0] ctl_req_index = '0;
    logic        ctl_req_update = 1'b0;
    logic [7:0]  ctl_req_prio = '0;
    logic        ctl_resp_valid;
    logic        ctl_resp_ready = 1'b1;
    logic [7:0]  ctl_resp_prio;
    logic        index_err;
    logic [15:0] ctl_starve_cnt;

    int checks = 0;
    int errors = 0;

    tx_msg_prio_arbiter #(.NUM_MSGS(128), .DEFAULT_PRIO(8'hFF)) dut (
        .clock(clock), .resetn(resetn),
        .eg_req_valid(eg_req_valid), .eg_req_index(eg_req_index),
        .eg_req_update(eg_req_update), .eg_req_prio(eg_req_prio),
        .eg_resp_valid(eg_resp_valid), .eg_resp_prio(eg_resp_prio),
        .ctl_req_valid(ctl_req_valid), .ctl_req_ready(ctl_req_ready),
        .ctl_req_index(ctl_req_index), .ctl_req_update(ctl_req_update),
        .ctl_req_prio(ctl_req_prio), .ctl_resp_valid(ctl_resp_valid),
        .ctl_resp_ready(ctl_resp_ready), .ctl_resp_prio(ctl_resp_prio),
        .index_err(index_err), .ctl_starve_cnt(ctl_starve_cnt)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic ev, input logic [15:0] ei, input logic eu, input logic [7:0] ep,
                         input logic cv, input logic [15:0] ci, input logic cu, input logic [7:0] cp,
                         input logic rr);
        eg_req_valid = ev; eg_req_index = ei; eg_req_update = eu; eg_req_prio = ep;
        ctl_req_valid = cv; ctl_req_index = ci; ctl_req_update = cu; ctl_req_prio = cp;
        ctl_resp_ready = rr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 1);
        #1;
        checks += 6;
        if (eg_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_eg_valid got %b exp 0", eg_resp_valid); end
        if (ctl_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_ctl_valid got %b exp 0", ctl_resp_valid); end
        if (index_err !== 1'b0) begin errors++; $display("FAIL rst_index_err got %b exp 0", index_err); end
        if (ctl_starve_cnt !== 16'h0) begin errors++; $display("FAIL rst_starve got %h exp 0", ctl_starve_cnt); end
        if (eg_resp_prio !== 8'h00 || ctl_resp_prio !== 8'h00) begin errors++; $display("FAIL rst_prio got %h/%h exp 00/00", eg_resp_prio, ctl_resp_prio); end
        if (ctl_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ctl_req_ready); end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        #1;
        checks++;
        if (ctl_req_ready !== 1'b0) begin errors++; $display("FAIL first_cycle_ready got %b exp 0", ctl_req_ready); end
        @(negedge clock);
        checks++;
        if (ctl_resp_valid !== 1'b0) begin errors++; $display("FAIL first_cycle_accept got %b exp 0", ctl_resp_valid); end
        idle();
        @(negedge clock);
    endtask

    task automatic test_eg_read();
        drive(1, 5, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        checks++;
        if (eg_resp_valid !== 1'b1 || eg_resp_prio !== 8'hFF) begin errors++; $display("FAIL eg_read5 got %b/%h exp 1/ff", eg_resp_valid, eg_resp_prio); end
        idle();
        @(negedge clock);
        checks++;
        if (eg_resp_valid !== 1'b0 || eg_resp_prio !== 8'h00) begin errors++; $display("FAIL eg_pulse got %b/%h exp 0/00", eg_resp_valid, eg_resp_prio); end
    endtask

    task automatic test_raw();
        drive(1, 3, 1, 8'h02, 0, 0, 0, 0, 1);
        @(negedge clock);
        checks++;
        if (eg_resp_valid !== 1'b1 || eg_resp_prio !== 8'hFF) begin errors++; $display("FAIL raw_pre got %b/%h exp 1/ff", eg_resp_valid, eg_resp_prio); end
        drive(1, 3, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        checks++;
        if (eg_resp_valid !== 1'b1 || eg_resp_prio !== 8'h02) begin errors++; $display("FAIL raw_post got %b/%h exp 1/02", eg_resp_valid, eg_resp_prio); end
        idle();
        @(negedge clock);
    endtask

    task automatic test_starve();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 1, 1, 0, 0, 1);
            #1;
            checks++;
            if (ctl_req_ready !== 1'b0) begin errors++; $display("FAIL starve_ready%0d got %b exp 0", k, ctl_req_ready); end
            @(negedge clock);
            checks++;
            if (ctl_resp_valid !== 1'b0) begin errors++; $display("FAIL starve_noacc%0d got %b exp 0", k, ctl_resp_valid); end
        end
        drive(0, 0, 0, 0, 1, 1, 0, 0, 1);
        #1;
        checks += 2;
        if (ctl_req_ready !== 1'b1) begin errors++; $display("FAIL starve_free_ready got %b exp 1", ctl_req_ready); end
        if (ctl_starve_cnt !== 16'd4) begin errors++; $display("FAIL starve_cnt got %0d exp 4", ctl_starve_cnt); end
        @(negedge clock);
        checks += 2;
        if (ctl_resp_valid !== 1'b1 || ctl_resp_prio !== 8'hFF) begin errors++; $display("FAIL starve_resp got %b/%h exp 1/ff", ctl_resp_valid, ctl_resp_prio); end
        if (ctl_starve_cnt !== 16'd4) begin errors++; $display("FAIL starve_cnt_hold got %0d exp 4", ctl_starve_cnt); end
        idle();
        @(negedge clock);
        checks++;
        if (ctl_resp_valid !== 1'b0 || ctl_resp_prio !== 8'h00) begin errors++; $display("FAIL starve_consumed got %b/%h exp 0/00", ctl_resp_valid, ctl_resp_prio); end
    endtask

    task automatic test_ctl_hold();
        drive(0, 0, 0, 0, 1, 3, 0, 0, 0);
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ctl_resp_valid !== 1'b1 || ctl_resp_prio !== 8'h02) begin errors++; $display("FAIL hold%0d got %b/%h exp 1/02", k, ctl_resp_valid, ctl_resp_prio); end
            drive(0, 0, 0, 0, 1, 4, 0, 0, 0);
            #1;
            checks++;
            if (ctl_req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready%0d got %b exp 0", k, ctl_req_ready); end
            @(negedge clock);
        end
        checks++;
        if (ctl_resp_valid !== 1'b1 || ctl_resp_prio !== 8'h02) begin errors++; $display("FAIL hold_last got %b/%h exp 1/02", ctl_resp_valid, ctl_resp_prio); end
        drive(0, 0, 0, 0, 1, 4, 0, 0, 1);
        #1;
        checks++;
        if (ctl_req_ready !== 1'b1) begin errors++; $display("FAIL consume_ready got %b exp 1", ctl_req_ready); end
        @(negedge clock);
        checks++;
        if (ctl_resp_valid !== 1'b1 || ctl_resp_prio !== 8'hFF) begin errors++; $display("FAIL second_resp got %b/%h exp 1/ff", ctl_resp_valid, ctl_resp_prio); end
        idle();
        @(negedge clock);
        checks++;
        if (ctl_resp_valid !== 1'b0) begin errors++; $display("FAIL second_consumed got %b exp 0", ctl_resp_valid); end
    endtask

    task automatic test_out_of_range();
        drive(1, 200, 1, 8'h55, 0, 0, 0, 0, 1);
        @(negedge clock);
        checks++;
        if (eg_resp_valid !== 1'b1 || eg_resp_prio !== 8'h00 || index_err !== 1'b1) begin
            errors++; $display("FAIL oor_resp got %b/%h/%b exp 1/00/1", eg_resp_valid, eg_resp_prio, index_err);
        end
        drive(1, 72, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        checks++;
        if (eg_resp_prio !== 8'hFF || index_err !== 1'b0) begin errors++; $display("FAIL oor_alias got %h/%b exp ff/0", eg_resp_prio, index_err); end
        idle();
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 0, 1, 3, 0, 0, 0);
        @(negedge clock);
        checks++;
        if (ctl_resp_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got %b exp 1", ctl_resp_valid); end
        drive(1, 9, 1, 8'h11, 0, 0, 0, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        checks += 2;
        if (ctl_resp_valid !== 1'b0 || ctl_resp_prio !== 8'h00) begin errors++; $display("FAIL mid_async got %b/%h exp 0/00", ctl_resp_valid, ctl_resp_prio); end
        if (ctl_starve_cnt !== 16'h0) begin errors++; $display("FAIL mid_starve got %0d exp 0", ctl_starve_cnt); end
        idle();
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        checks++;
        if (ctl_resp_valid !== 1'b0 || eg_resp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_resp got %b/%b exp 0/0", ctl_resp_valid, eg_resp_valid); end
        drive(1, 3, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        checks++;
        if (eg_resp_prio !== 8'hFF) begin errors++; $display("FAIL mid_entry3 got %h exp ff", eg_resp_prio); end
        drive(1, 9, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        checks++;
        if (eg_resp_prio !== 8'hFF) begin errors++; $display("FAIL mid_entry9 got %h exp ff", eg_resp_prio); end
        idle();
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [7:0]  mem [128];
        logic        m_eg_v = 0, m_cv = 0, m_err = 0;
        logic [7:0]  m_eg_p = 0, m_cp = 0, rd;
        int          m_starve = 0;
        logic        ev, cv, rr, upd, acc_e, acc_c, m_ready;
        logic [15:0] idx;
        logic [7:0]  wp;
        for (int i = 0; i < 128; i++) mem[i] = 8'hFF;
        for (int n = 0; n < 600; n++) begin
            checks += 6;
            if (eg_resp_valid !== m_eg_v || eg_resp_prio !== m_eg_p) begin errors++; $display("FAIL rnd_eg cyc %0d got %b/%h exp %b/%h", n, eg_resp_valid, eg_resp_prio, m_eg_v, m_eg_p); end
            if (ctl_resp_valid !== m_cv) begin errors++; $display("FAIL rnd_ctl_valid cyc %0d got %b exp %b", n, ctl_resp_valid, m_cv); end
            if (ctl_resp_prio !== m_cp) begin errors++; $display("FAIL rnd_ctl_prio cyc %0d got %h exp %h", n, ctl_resp_prio, m_cp); end
            if (index_err !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", n, index_err, m_err); end
            if (ctl_starve_cnt !== 16'(m_starve)) begin errors++; $display("FAIL rnd_starve cyc %0d got %0d exp %0d", n, ctl_starve_cnt, m_starve); end
            ev = $urandom_range(0, 99) < 35;
            cv = $urandom_range(0, 99) < 60;
            rr = $urandom_range(0, 99) < 70;
            drive(ev, ($urandom_range(0, 9) == 0) ? 16'($urandom_range(128, 300)) : 16'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom),
                  cv, ($urandom_range(0, 9) == 0) ? 16'($urandom_range(128, 300)) : 16'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom), rr);
            #1;
            m_ready = !ev && (!m_cv || rr);
            if (ctl_req_ready !== m_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", n, ctl_req_ready, m_ready); end
            acc_e = ev;
            acc_c = cv && m_ready;
            idx = acc_e ? eg_req_index : ctl_req_index;
            upd = acc_e ? eg_req_update : ctl_req_update;
            wp  = acc_e ? eg_req_prio : ctl_req_prio;
            rd  = (idx < 128) ? mem[idx[6:0]] : 8'h00;
            m_eg_v = acc_e;
            m_eg_p = acc_e ? rd : 8'h00;
            m_err  = (acc_e || acc_c) && idx >= 128;
            if (acc_c) begin m_cv = 1; m_cp = rd; end
            else if (rr) begin m_cv = 0; m_cp = 8'h00; end
            if ((acc_e || acc_c) && upd && idx < 128) mem[idx[6:0]] = wp;
            if (ev && cv && m_starve < 65535) m_starve++;
            @(negedge clock);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_eg_read();
        test_raw();
        test_starve();
        test_ctl_hold();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
